// File: rtl/bl_serial_alu.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : bl_serial_alu
// Purpose  : Bit-serial, column-parallel ALU fed from bit-line sensing.
//            Each column sees BL = A&B and BLB = ~A&~B for the current bit
//            slice (LSB first) and produces one result bit per slice.
//            Supports ADD (ripple carry kept per column), AND, OR, XOR.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start/mode/cin  - begin an operation (accepted only when ready)
//            abort           - cancel an operation in progress
//            bit_valid/bl/blb- one sensed bit slice per accepted cycle
//            ready           - high only while idle
//            sum_valid/sum/bit_idx - registered result slice and its row
//            done/cout/ovf   - final-slice pulse, per-column carry/overflow
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module bl_serial_alu #(
   parameter int COLS      = 8,
   parameter int WORD_BITS = 8,
   localparam int IDX_W    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             cin,
   input  logic             abort,
   input  logic             bit_valid,
   input  logic [COLS-1:0]  bl,
   input  logic [COLS-1:0]  blb,
   output logic             ready,
   output logic             sum_valid,
   output logic [COLS-1:0]  sum,
   output logic [IDX_W-1:0] bit_idx,
   output logic             done,
   output logic [COLS-1:0]  cout,
   output logic [COLS-1:0]  ovf
);

   localparam logic [1:0]       c_mode_add = 2'd0;
   localparam logic [1:0]       c_mode_and = 2'd1;
   localparam logic [1:0]       c_mode_or  = 2'd2;
   localparam logic [IDX_W-1:0] c_last     = IDX_W'(WORD_BITS - 1);
   localparam logic [IDX_W-1:0] c_one      = IDX_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           r_state;
   logic [1:0]       r_mode;
   logic [COLS-1:0]  r_carry;
   logic [IDX_W-1:0] r_cnt;
   logic [COLS-1:0]  r_sum;
   logic [IDX_W-1:0] r_bit_idx;
   logic             r_sum_valid;
   logic             r_done;
   logic [COLS-1:0]  r_cout;
   logic [COLS-1:0]  r_ovf;

   logic [COLS-1:0]  w_x;
   logic [COLS-1:0]  w_add_sum;
   logic [COLS-1:0]  w_add_carry;
   logic [COLS-1:0]  w_slice;

   // Neither line discharged means A and B differ, so X = A^B.
   assign w_x         = ~(bl | blb);
   assign w_add_sum   = w_x ^ r_carry;
   // Generate when both are 1 (BL), propagate when they differ.
   assign w_add_carry = bl | (w_x & r_carry);

   always_comb begin
      w_slice = w_x;
      case (r_mode)
         c_mode_add: w_slice = w_add_sum;
         c_mode_and: w_slice = bl;
         c_mode_or:  w_slice = ~blb;
         default:    w_slice = w_x;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_mode      <= 2'd0;
         r_carry     <= '0;
         r_cnt       <= '0;
         r_sum       <= '0;
         r_bit_idx   <= '0;
         r_sum_valid <= 1'b0;
         r_done      <= 1'b0;
         r_cout      <= '0;
         r_ovf       <= '0;
      end else begin
         r_sum_valid <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_mode  <= mode;
                  r_carry <= {COLS{cin}};
                  r_cnt   <= '0;
                  r_cout  <= '0;
                  r_ovf   <= '0;
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else if (bit_valid) begin
                  r_sum       <= w_slice;
                  r_bit_idx   <= r_cnt;
                  r_sum_valid <= 1'b1;
                  r_cnt       <= r_cnt + c_one;
                  if (r_mode == c_mode_add) begin
                     r_carry <= w_add_carry;
                  end
                  if (r_cnt == c_last) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                     if (r_mode == c_mode_add) begin
                        r_cout <= w_add_carry;
                        // r_carry still holds the carry into the MSB here.
                        r_ovf  <= r_carry ^ w_add_carry;
                     end
                  end
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready     = (r_state == S_IDLE);
   assign sum_valid = r_sum_valid;
   assign sum       = r_sum;
   assign bit_idx   = r_bit_idx;
   assign done      = r_done;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bl_serial_alu.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : tb_bl_serial_alu
// Purpose  : Self-checking bench for bl_serial_alu (COLS=4, WORD_BITS=4).
//            Operands are held as whole words per column; the expected
//            result, carry and overflow come from plain arithmetic.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_bl_serial_alu;

   localparam int COLS = 4;
   localparam int WB   = 4;

   logic       clk = 1'b0;
   logic       rst, start, cin, abort, bit_valid;
   logic [1:0] mode;
   logic [COLS-1:0] bl, blb;
   logic       ready, sum_valid, done;
   logic [COLS-1:0] sum, cout, ovf;
   logic [1:0] bit_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bl_serial_alu #(.COLS(COLS), .WORD_BITS(WB)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .cin(cin),
      .abort(abort), .bit_valid(bit_valid), .bl(bl), .blb(blb),
      .ready(ready), .sum_valid(sum_valid), .sum(sum), .bit_idx(bit_idx),
      .done(done), .cout(cout), .ovf(ovf)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Reference: column c uses operand bits [4c+3:4c] of the packed words.
   function automatic void model(input logic [1:0] m, input logic ci,
                                 input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] res,
                                 output logic [3:0] co, output logic [3:0] ov);
      res = '0; co = '0; ov = '0;
      for (int c = 0; c < COLS; c++) begin
         logic [3:0] ac, bc, r4;
         int s;
         ac = a[4*c +: 4];
         bc = b[4*c +: 4];
         case (m)
            2'd0: begin
               s  = int'(ac) + int'(bc) + int'(ci);
               r4 = s[3:0];
               co[c] = (s > 15);
               ov[c] = (ac[3] == bc[3]) && (r4[3] != ac[3]);
            end
            2'd1:    r4 = ac & bc;
            2'd2:    r4 = ac | bc;
            default: r4 = ac ^ bc;
         endcase
         res[4*c +: 4] = r4;
      end
   endfunction

   // Runs one complete operation, checking every slice against the model.
   task automatic run_op(input logic [1:0] m, input logic ci,
                         input logic [15:0] a, input logic [15:0] b,
                         input int max_gap, input bit glitch,
                         output logic [15:0] act_res,
                         output logic [3:0] act_co, output logic [3:0] act_ov);
      logic [15:0] er;
      logic [3:0]  eco, eov, eslice;
      int gap;
      model(m, ci, a, b, er, eco, eov);
      act_res = '0;
      start = 1'b1; mode = m; cin = ci;
      step;
      start = 1'b0;
      checks++;
      if ({ready, cout, ovf} !== 9'd0) begin
         errors++;
         $display("FAIL start_clear: ready/cout/ovf=%b required 0", {ready, cout, ovf});
      end
      for (int i = 0; i < WB; i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int g = 0; g < gap; g++) begin
            bit_valid = 1'b0;
            step;
            checks++;
            if (sum_valid !== 1'b0) begin
               errors++;
               $display("FAIL gap_valid: sum_valid=%b required 0", sum_valid);
            end
         end
         bit_valid = 1'b1;
         for (int c = 0; c < COLS; c++) begin
            bl[c]     = a[4*c+i] & b[4*c+i];
            blb[c]    = ~a[4*c+i] & ~b[4*c+i];
            eslice[c] = er[4*c+i];
         end
         if (glitch && i == 1) begin
            start = 1'b1; mode = ~m; cin = ~ci;
         end
         step;
         start = 1'b0;
         checks++;
         if (sum_valid !== 1'b1 || bit_idx !== 2'(i) || sum !== eslice ||
             done !== (i == WB - 1)) begin
            errors++;
            $display("FAIL slice%0d: valid=%b idx=%0d sum=%b done=%b required 1 %0d %b %b",
                     i, sum_valid, bit_idx, sum, done, i, eslice, (i == WB - 1));
         end
         for (int c = 0; c < COLS; c++) act_res[4*c+i] = sum[c];
      end
      bit_valid = 1'b0;
      act_co = cout;
      act_ov = ovf;
      checks++;
      if (cout !== eco || ovf !== eov) begin
         errors++;
         $display("FAIL final_flags: cout=%b ovf=%b required %b %b", cout, ovf, eco, eov);
      end
      step;
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || sum_valid !== 1'b0 || cout !== eco ||
          ovf !== eov || sum !== eslice) begin
         errors++;
         $display("FAIL post_op: ready=%b done=%b valid=%b cout=%b ovf=%b sum=%b required 1 0 0 %b %b %b",
                  ready, done, sum_valid, cout, ovf, sum, eco, eov, eslice);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step;
      checks++;
      if (ready !== 1'b1 || sum_valid !== 1'b0 || done !== 1'b0 || sum !== 4'd0 ||
          bit_idx !== 2'd0 || cout !== 4'd0 || ovf !== 4'd0) begin
         errors++;
         $display("FAIL reset: ready=%b valid=%b done=%b sum=%b idx=%0d cout=%b ovf=%b required 1 0 0 0 0 0 0",
                  ready, sum_valid, done, sum, bit_idx, cout, ovf);
      end
      step;
      rst = 1'b0;
   endtask

   task automatic test_add;
      logic [15:0] r; logic [3:0] co, ov;
      run_op(2'd0, 1'b0, 16'h0003, 16'h0005, 0, 1'b0, r, co, ov);
      checks++;
      if (r[3:0] !== 4'd8 || co[0] !== 1'b0 || ov[0] !== 1'b1) begin
         errors++;
         $display("FAIL add_3_5: sum=%0d cout=%b ovf=%b required 8 0 1", r[3:0], co[0], ov[0]);
      end
      run_op(2'd0, 1'b0, 16'h00F0, 16'h0010, 0, 1'b0, r, co, ov);
      checks++;
      if (r !== 16'h0000 || co !== 4'b0010 || ov !== 4'b0000) begin
         errors++;
         $display("FAIL add_15_1: sum=%h cout=%b ovf=%b required 0000 0010 0000", r, co, ov);
      end
      run_op(2'd0, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, r, co, ov);
      checks++;
      if (r !== 16'h1111 || co !== 4'b0000 || ov !== 4'b0000) begin
         errors++;
         $display("FAIL add_cin: sum=%h cout=%b ovf=%b required 1111 0000 0000", r, co, ov);
      end
   endtask

   task automatic test_logic;
      logic [15:0] r; logic [3:0] co, ov;
      logic [15:0] exp_tab [3];
      exp_tab[0] = 16'h6666; exp_tab[1] = 16'h8888; exp_tab[2] = 16'hEEEE;
      for (int k = 0; k < 3; k++) begin
         logic [1:0] m;
         m = (k == 0) ? 2'd3 : 2'(k);
         run_op(m, 1'b1, 16'hCCCC, 16'hAAAA, 0, 1'b0, r, co, ov);
         checks++;
         if (r !== exp_tab[k] || co !== 4'd0 || ov !== 4'd0) begin
            errors++;
            $display("FAIL logic_mode%0d: sum=%h cout=%b ovf=%b required %h 0000 0000",
                     m, r, co, ov, exp_tab[k]);
         end
      end
   endtask

   task automatic test_abort_reset;
      logic [15:0] r; logic [3:0] co, ov;
      start = 1'b1; mode = 2'd0; cin = 1'b0;
      step;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bit_valid = 1'b1; bl = 4'b0101; blb = 4'b0000;
         step;
      end
      abort = 1'b1;
      step;
      abort = 1'b0; bit_valid = 1'b0;
      checks++;
      if (ready !== 1'b1 || sum_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort: ready=%b valid=%b done=%b required 1 0 0", ready, sum_valid, done);
      end
      step;
      checks++;
      if (done !== 1'b0 || sum_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_after: done=%b valid=%b required 0 0", done, sum_valid);
      end
      start = 1'b1; mode = 2'd0; cin = 1'b1;
      step;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bit_valid = 1'b1; bl = 4'b1111; blb = 4'b0000;
         step;
      end
      rst = 1'b1;
      step;
      rst = 1'b0; bit_valid = 1'b0;
      checks++;
      if (ready !== 1'b1 || sum_valid !== 1'b0 || done !== 1'b0 || sum !== 4'd0 ||
          bit_idx !== 2'd0 || cout !== 4'd0 || ovf !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset: ready=%b valid=%b done=%b sum=%b idx=%0d cout=%b ovf=%b required 1 0 0 0 0 0 0",
                  ready, sum_valid, done, sum, bit_idx, cout, ovf);
      end
      for (int i = 0; i < 3; i++) begin
         step;
         checks++;
         if (done !== 1'b0 || sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: done=%b valid=%b required 0 0", done, sum_valid);
         end
      end
      run_op(2'd0, 1'b0, 16'h7F39, 16'h1A6C, 0, 1'b0, r, co, ov);
   endtask

   task automatic test_back_to_back;
      logic [15:0] r; logic [3:0] co, ov;
      bit_valid = 1'b1; bl = 4'b1010; blb = 4'b0101;
      for (int i = 0; i < 2; i++) begin
         step;
         checks++;
         if (sum_valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_bit_valid: valid=%b ready=%b required 0 1", sum_valid, ready);
         end
      end
      bit_valid = 1'b0;
      // Start pulsed mid-operation with a different mode and carry.
      run_op(2'd0, 1'b0, 16'h9E47, 16'h35D8, 0, 1'b1, r, co, ov);
      run_op(2'd3, 1'b1, 16'h5A5A, 16'h0FF0, 0, 1'b1, r, co, ov);
   endtask

   task automatic test_random;
      logic [15:0] r; logic [3:0] co, ov;
      for (int n = 0; n < 30; n++) begin
         run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom), 2, 1'b0, r, co, ov);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; mode = 2'd0; cin = 1'b0; abort = 1'b0;
      bit_valid = 1'b0; bl = '0; blb = '0;
      #1;
      test_reset;
      test_add;
      test_logic;
      test_abort_reset;
      test_back_to_back;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bl_serial_alu.md
BL_SERIAL_ALU -- requirements
Module: bl_serial_alu

Interface
REQ-001 SHALL have parameter COLS, default 8, number of bit-line columns processed in parallel (>=1).
REQ-002 SHALL have parameter WORD_BITS, default 8, operand width in bits, processed LSB first (>=1).
REQ-003 SHALL have CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have RST  input  1  synchronous active-high reset, sampled on the CLK rising edge.
REQ-005 SHALL have START  input  1  begins an operation when READY=1.
REQ-006 SHALL have MODE  input  2  operation, latched at START: 0=ADD, 1=AND, 2=OR, 3=XOR.
REQ-007 SHALL have CIN  input  1  initial carry for all columns, latched at START.
REQ-008 SHALL have ABORT  input  1  cancels an operation in progress.
REQ-009 SHALL have BIT_VALID  input  1  BL/BLB carry the current bit slice.
REQ-010 SHALL have BL  input  COLS  per-column A&B sensed on the bit line.
REQ-011 SHALL have BLB  input  COLS  per-column ~A&~B sensed on the bit-line-bar.
REQ-012 SHALL have READY  output  1  high only in IDLE.
REQ-013 SHALL have SUM_VALID  output  1  one-cycle pulse qualifying SUM and BIT_IDX.
REQ-014 SHALL have SUM  output  COLS  result bit slice, one bit per column.
REQ-015 SHALL have BIT_IDX  output  max(1,clog2(WORD_BITS))  bit position of SUM, for write-back row addressing.
REQ-016 SHALL have DONE  output  1  one-cycle pulse marking the final slice.
REQ-017 SHALL have COUT  output  COLS  per-column final carry, valid while DONE=1 and held until the next START.
REQ-018 SHALL have OVF  output  COLS  per-column signed overflow (carry into MSB XOR carry out), same timing as COUT.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, FIN.
- IDLE -> RUN on START.
- RUN -> FIN on acceptance of bit WORD_BITS-1.
- RUN -> IDLE on ABORT.
- FIN -> IDLE unconditionally after one cycle.
REQ-020 SHALL, on START in IDLE, latch MODE, set every column carry to CIN, clear the bit counter, and clear COUT and OVF.
REQ-021 SHALL ignore START outside IDLE, and ignore BIT_VALID in IDLE and FIN.
REQ-022 SHALL, per column in RUN with BIT_VALID=1, form X = ~(BL|BLB) (equal to A^B) and compute the result:
- ADD: SUM = X^C; new C = BL | (X&C).
- AND: SUM = BL.
- OR: SUM = ~BLB.
- XOR: SUM = X.
- In all logic modes the carry is unchanged.
REQ-023 SHALL register SUM and BIT_IDX, with SUM_VALID=1 exactly one cycle after each accepted BIT_VALID; BIT_VALID may stay high on consecutive cycles with no bubbles.
REQ-024 SHALL increment the bit counter per accepted slice; on slice WORD_BITS-1, in the following cycle assert DONE together with the last SUM_VALID and present COUT and OVF.
REQ-025 SHALL report COUT=0 and OVF=0 in the logic modes.
REQ-026 SHALL, for WORD_BITS=1, make the first accepted slice also the last (DONE on its SUM_VALID); OVF then equals CIN^COUT.
REQ-027 SHALL, on ABORT in RUN, go to IDLE the next cycle with no DONE and no SUM_VALID for that cycle's slice; ABORT takes priority over a simultaneous BIT_VALID.
REQ-028 SHALL hold SUM and BIT_IDX stable between SUM_VALID pulses.

Reset
REQ-029 SHALL, while RST=1, drive state=IDLE, READY=1 on the following cycle, SUM_VALID=0, DONE=0, SUM=0, BIT_IDX=0, COUT=0, OVF=0, and set all carries and the bit counter to 0.
REQ-030 SHALL give RST priority over START, ABORT and BIT_VALID, including mid-operation: no DONE is produced for the interrupted operation.

Verification (COLS=4, WORD_BITS=4 unless noted)
REQ-031 SHALL cover ADD, CIN=0, column 0 with A=3 and B=5; LSB-first (BL,BLB)=(1,0),(0,0),(0,0),(0,1) -> SUM bits 0,0,0,1 (8), BIT_IDX 0..3, COUT[0]=0, OVF[0]=1, DONE on the 4th SUM_VALID.
REQ-032 SHALL cover ADD with A=15 and B=1 in column 1 -> SUM=0, COUT[1]=1, OVF[1]=0; the other columns, driven with A=B=0, give SUM=0 and COUT=0.
REQ-033 SHALL cover ADD, CIN=1, A=B=0 in all columns -> SUM=1 in every column, COUT=0, OVF=0.
REQ-034 SHALL cover XOR, AND and OR with A=0b1100 and B=0b1010 -> XOR 0b0110, AND 0b1000, OR 0b1110, with COUT=0 and OVF=0.
REQ-035 SHALL cover ABORT after 2 slices -> READY=1 the next cycle, no DONE; then RST asserted after 2 slices of a new op -> all outputs 0, READY=1; then a fresh START runs correctly.
REQ-036 SHALL cover back-to-back BIT_VALID, START during RUN (ignored), and BIT_VALID in IDLE (no SUM_VALID).
